demux_stream_ctrl: RTL and testbench

Registered, flow-controlled steering controller for a 16-bit word stream split across two destinations (A and B). It picks the destination for each accepted input word in one of three modes: explicit destination bit, strict alternation, or fixed-length bursts. It holds each routed word in a per-destination output register until that destination accepts it, and counts delivered words per destination. It sits between a single upstream producer and two downstream consumers, replacing the bare 1x2 demux wherever back-pressure or scheduled sharing is needed.

---
 rtl/demux_stream_ctrl_if.sv | 31 +++
 rtl/demux_stream_ctrl.sv | 131 +++++++++++++
 tb/tb_demux_stream_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_ctrl_if.sv
// Stream bundle for demux_stream_ctrl: one upstream producer, two downstream consumers
// (A and B), the routing mode and the per-destination delivery counters.
interface demux_stream_ctrl_if #(
    parameter int size = 16
);
    logic [1:0]      mode;
    logic [size-1:0] in_data;
    logic            in_dest;
    logic            in_valid;
    logic            in_ready;
    logic [size-1:0] outA_data;
    logic [size-1:0] outB_data;
    logic            outA_valid;
    logic            outB_valid;
    logic            outA_ready;
    logic            outB_ready;
    logic [7:0]      countA;
    logic [7:0]      countB;

    // Environment side: drives the producer and both consumers
    modport master (
        output mode, in_data, in_dest, in_valid, outA_ready, outB_ready,
        input  in_ready, outA_data, outB_data, outA_valid, outB_valid, countA, countB
    );

    // Controller side
    modport slave (
        input  mode, in_data, in_dest, in_valid, outA_ready, outB_ready,
        output in_ready, outA_data, outB_data, outA_valid, outB_valid, countA, countB
    );
endinterface

// File: rtl/demux_stream_ctrl.sv
// Flow-controlled 1x2 stream steering: routes each accepted word to A or B by explicit
// destination, alternation or fixed bursts, holding it in a per-destination register.
module demux_stream_ctrl #(
    parameter int size  = 16,
    parameter int BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    demux_stream_ctrl_if.slave bus
);
    localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

    typedef enum logic {
        SEND_A = 1'b0,
        SEND_B = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [7:0]      bcnt_reg;
    logic [7:0]      bcnt_next;
    logic [1:0]      mode_q_reg;

    logic            mode_ok;
    logic            tgt;
    logic            in_ready;
    logic            accept;
    logic [1:0]      out_ready;
    logic [1:0]      out_valid;
    logic [1:0]      free;
    logic [size-1:0] out_data  [2];
    logic [7:0]      out_count [2];

    assign out_ready = {bus.outB_ready, bus.outA_ready};
    assign mode_ok   = (bus.mode == mode_q_reg);

    // Scheduled modes steer by the pointer; everything else honours in_dest
    always_comb begin
        tgt = bus.in_dest;
        if (mode_q_reg == 2'b01 || mode_q_reg == 2'b10) begin
            tgt = state_reg;
        end
    end

    assign in_ready = !rst && mode_ok && free[tgt];
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= SEND_A;
            bcnt_reg   <= '0;
            mode_q_reg <= 2'b00;
        end else begin
            state_reg  <= state_next;
            bcnt_reg   <= bcnt_next;
            mode_q_reg <= bus.mode;
        end
    end

    // A mode change blocks acceptance for the cycle, so it never races an advance
    always_comb begin
        state_next = state_reg;
        bcnt_next  = bcnt_reg;
        if (!mode_ok) begin
            state_next = SEND_A;
            bcnt_next  = '0;
        end else if (accept) begin
            case (mode_q_reg)
                2'b01: begin
                    state_next = (state_reg == SEND_A) ? SEND_B : SEND_A;
                end
                2'b10: begin
                    if (bcnt_reg == BURST_LAST) begin
                        bcnt_next  = '0;
                        state_next = (state_reg == SEND_A) ? SEND_B : SEND_A;
                    end else begin
                        bcnt_next = bcnt_reg + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dest
            logic [size-1:0] data_reg;
            logic            valid_reg;
            logic [7:0]      count_reg;
            logic            load;
            logic            handshake;

            assign load      = accept && (tgt == 1'(gi));
            assign handshake = valid_reg && out_ready[gi];
            assign free[gi]  = !valid_reg || out_ready[gi];

            // A load in the same cycle as a drain keeps valid high with the new word
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    count_reg <= '0;
                end else begin
                    if (load) begin
                        data_reg  <= bus.in_data;
                        valid_reg <= 1'b1;
                    end else if (handshake) begin
                        valid_reg <= 1'b0;
                    end
                    if (handshake) begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
            end

            assign out_data[gi]  = data_reg;
            assign out_valid[gi] = valid_reg;
            assign out_count[gi] = count_reg;
        end
    endgenerate

    assign bus.in_ready   = in_ready;
    assign bus.outA_data  = out_data[0];
    assign bus.outB_data  = out_data[1];
    assign bus.outA_valid = out_valid[0];
    assign bus.outB_valid = out_valid[1];
    assign bus.countA     = out_count[0];
    assign bus.countB     = out_count[1];
endmodule

// File: tb/tb_demux_stream_ctrl.sv
// Directed bench for demux_stream_ctrl: stimulus pushes expected words per destination,
// a negedge monitor pops and compares on every output handshake.
module tb_demux_stream_ctrl;
    logic clk;
    logic rst;
    int   errors;
    int   checks;
    logic [15:0] qA[$];
    logic [15:0] qB[$];

    demux_stream_ctrl_if #(.size(16)) bus ();

    demux_stream_ctrl #(.size(16), .BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a handshake seen at negedge completes on the next rising edge
    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            if (bus.outA_valid && bus.outA_ready) begin
                if (qA.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL outA_unexpected: got 0x%0h expected no word", bus.outA_data);
                end else begin
                    e = qA.pop_front();
                    chk("outA_word", int'(bus.outA_data), int'(e));
                    $display("A <- 0x%04h (expected 0x%04h)", bus.outA_data, e);
                end
            end
            if (bus.outB_valid && bus.outB_ready) begin
                if (qB.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL outB_unexpected: got 0x%0h expected no word", bus.outB_data);
                end else begin
                    e = qB.pop_front();
                    chk("outB_word", int'(bus.outB_data), int'(e));
                    $display("B <- 0x%04h (expected 0x%04h)", bus.outB_data, e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic dest_in, input logic exp_b);
        int n;
        n = 0;
        bus.in_data  = d;
        bus.in_dest  = dest_in;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: got in_ready=0 for word 0x%04h expected accept", d);
        end else if (exp_b) begin
            qB.push_back(d);
        end else begin
            qA.push_back(d);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic set_mode(input logic [1:0] m);
        bus.mode     = m;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mode_change_stall", int'(bus.in_ready), 0);
        @(posedge clk); #1;
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst            = 1'b1;
        bus.mode       = 2'b00;
        bus.in_data    = '0;
        bus.in_dest    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(bus.in_ready), 0);
        chk("rst_outA_valid", int'(bus.outA_valid), 0);
        chk("rst_countB", int'(bus.countB), 0);
        rst = 1'b0;

        // explicit destination, first accept possible immediately after reset
        send(16'h1111, 1'b0, 1'b0);
        chk("latency_A_valid", int'(bus.outA_valid), 1);
        chk("latency_A_data", int'(bus.outA_data), 16'h1111);
        send(16'h2222, 1'b1, 1'b1);
        chk("latency_B_data", int'(bus.outB_data), 16'h2222);
        settle();
        chk("t1_countA", int'(bus.countA), 1);
        chk("t1_countB", int'(bus.countB), 1);

        // back-pressure on A, then drain and reload in the same cycle
        bus.outA_ready = 1'b0;
        send(16'hAAAA, 1'b0, 1'b0);
        bus.in_data  = 16'hBBBB;
        bus.in_dest  = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("blocked_in_ready", int'(bus.in_ready), 0);
            chk("blocked_hold", int'(bus.outA_data), 16'hAAAA);
        end
        @(posedge clk); #1;
        bus.outA_ready = 1'b1;
        @(negedge clk);
        chk("drain_load_ready", int'(bus.in_ready), 1);
        qA.push_back(16'hBBBB);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("reload_valid", int'(bus.outA_valid), 1);
        chk("reload_data", int'(bus.outA_data), 16'hBBBB);
        settle();
        chk("t2_countA", int'(bus.countA), 3);

        // alternation, in_dest ignored
        set_mode(2'b01);
        for (int i = 1; i <= 6; i++) begin
            send(16'(i), 1'b1, (i % 2) == 0);
        end
        settle();
        chk("t3_countA", int'(bus.countA), 6);
        chk("t3_countB", int'(bus.countB), 4);

        // back-to-back mode changes, then bursts of 4 with B blocked on word 6
        set_mode(2'b11);
        set_mode(2'b10);
        for (int i = 1; i <= 4; i++) send(16'(i), 1'b1, 1'b0);
        bus.outB_ready = 1'b0;
        send(16'h0005, 1'b0, 1'b1);
        bus.in_data  = 16'h0006;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("burst_stall_ready", int'(bus.in_ready), 0);
            chk("burst_no_A", int'(bus.outA_valid), 0);
        end
        @(posedge clk); #1;
        bus.outB_ready = 1'b1;
        for (int i = 6; i <= 8; i++) send(16'(i), 1'b0, 1'b1);
        for (int i = 9; i <= 10; i++) send(16'(i), 1'b1, 1'b0);
        settle();
        chk("t4_countA", int'(bus.countA), 12);
        chk("t4_countB", int'(bus.countB), 8);

        // asynchronous reset with both registers full
        set_mode(2'b01);
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        send(16'h5A5A, 1'b0, 1'b0);
        send(16'hA5A5, 1'b0, 1'b1);
        chk("full_A_valid", int'(bus.outA_valid), 1);
        chk("full_B_valid", int'(bus.outB_valid), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_A_valid", int'(bus.outA_valid), 0);
        chk("async_B_valid", int'(bus.outB_valid), 0);
        chk("async_A_data", int'(bus.outA_data), 0);
        chk("async_B_data", int'(bus.outB_data), 0);
        chk("async_countA", int'(bus.countA), 0);
        chk("async_countB", int'(bus.countB), 0);
        chk("async_in_ready", int'(bus.in_ready), 0);
        qA.delete();
        qB.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_stall", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        send(16'h0C0C, 1'b1, 1'b0);
        send(16'h0D0D, 1'b0, 1'b1);
        settle();
        chk("t6_countA", int'(bus.countA), 1);
        chk("t6_countB", int'(bus.countB), 1);

        // countA wrap: 256 handshakes since reset
        set_mode(2'b00);
        for (int i = 0; i < 254; i++) send(16'(16'h1000 + i), 1'b0, 1'b0);
        settle();
        chk("countA_255", int'(bus.countA), 255);
        send(16'hFFFF, 1'b0, 1'b0);
        settle();
        chk("countA_wrap", int'(bus.countA), 0);
        chk("countB_hold", int'(bus.countB), 1);

        chk("qA_empty", qA.size(), 0);
        chk("qB_empty", qB.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
